arm_id_ex_operand_stage: RTL and testbench

//  Decode->Execute pipeline register for the ARM pipelined datapath, plus the forwarding and load-use logic
//  for the EX operand muxes. Registers D-stage operands/control into E and drives the 2-bit selects of the
//  ARM_Mux_4x1 operand muxes (SrcA/SrcB). Raises a stall request for load-use hazards and inserts the bubble itself.

---
 rtl/arm_id_ex_operand_stage.sv | 123 ++++++++++++
 tb/tb_arm_id_ex_operand_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/arm_id_ex_operand_stage.sv
// arm_id_ex_operand_stage: D->E pipeline register with EX operand forwarding selects and load-use bubble insertion.
module arm_id_ex_operand_stage #(
    parameter int BusWidth     = 32,
    parameter int RegAddrWidth = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_NRESET,
    input  logic                    i_Stall,
    input  logic                    i_Flush,
    input  logic                    i_ValidD,
    input  logic [BusWidth-1:0]     i_RD1D,
    input  logic [BusWidth-1:0]     i_RD2D,
    input  logic [BusWidth-1:0]     i_ImmD,
    input  logic [RegAddrWidth-1:0] i_RA1D,
    input  logic [RegAddrWidth-1:0] i_RA2D,
    input  logic [RegAddrWidth-1:0] i_WA3D,
    input  logic                    i_RegWriteD,
    input  logic                    i_MemToRegD,
    input  logic [RegAddrWidth-1:0] i_WA3M,
    input  logic [RegAddrWidth-1:0] i_WA3W,
    input  logic                    i_RegWriteM,
    input  logic                    i_RegWriteW,
    output logic [BusWidth-1:0]     o_RD1E,
    output logic [BusWidth-1:0]     o_RD2E,
    output logic [BusWidth-1:0]     o_ImmE,
    output logic [RegAddrWidth-1:0] o_RA1E,
    output logic [RegAddrWidth-1:0] o_RA2E,
    output logic [RegAddrWidth-1:0] o_WA3E,
    output logic                    o_RegWriteE,
    output logic                    o_MemToRegE,
    output logic                    o_ValidE,
    output logic [1:0]              o_ForwardAE,
    output logic [1:0]              o_ForwardBE,
    output logic                    o_StallReq
);
    localparam logic [RegAddrWidth-1:0] PC = RegAddrWidth'(15);

    logic [BusWidth-1:0]     rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [RegAddrWidth-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa3_q, wa3_d;
    logic                    reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d, valid_q, valid_d;
    logic                    stall_req, bubble;

    assign stall_req = valid_q && mem_to_reg_q && reg_write_q && i_ValidD && wa3_q != PC
                       && (wa3_q == i_RA1D || wa3_q == i_RA2D);
    // Flush beats stall; a load-use bubble only goes in when E is free to advance.
    assign bubble = i_Flush || (!i_Stall && stall_req);

    always_comb begin
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        ra1_d        = ra1_q;
        ra2_d        = ra2_q;
        wa3_d        = wa3_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        valid_d      = valid_q;
        if (bubble) begin
            rd1_d        = '0;
            rd2_d        = '0;
            imm_d        = '0;
            ra1_d        = '0;
            ra2_d        = '0;
            wa3_d        = '0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            valid_d      = 1'b0;
        end else if (!i_Stall) begin
            rd1_d        = i_RD1D;
            rd2_d        = i_RD2D;
            imm_d        = i_ImmD;
            ra1_d        = i_RA1D;
            ra2_d        = i_RA2D;
            wa3_d        = i_WA3D;
            reg_write_d  = i_RegWriteD && i_ValidD;
            mem_to_reg_d = i_MemToRegD && i_ValidD;
            valid_d      = i_ValidD;
        end
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            ra1_q        <= '0;
            ra2_q        <= '0;
            wa3_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            ra1_q        <= ra1_d;
            ra2_q        <= ra2_d;
            wa3_q        <= wa3_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            valid_q      <= valid_d;
        end
    end

    // M result is younger than W, so it wins; the PC is never forwarded.
    always_comb begin
        o_ForwardAE = (i_RegWriteM && i_WA3M == ra1_q && ra1_q != PC) ? 2'b10 :
                      (i_RegWriteW && i_WA3W == ra1_q && ra1_q != PC) ? 2'b01 : 2'b00;
        o_ForwardBE = (i_RegWriteM && i_WA3M == ra2_q && ra2_q != PC) ? 2'b10 :
                      (i_RegWriteW && i_WA3W == ra2_q && ra2_q != PC) ? 2'b01 : 2'b00;
    end

    assign o_RD1E      = rd1_q;
    assign o_RD2E      = rd2_q;
    assign o_ImmE      = imm_q;
    assign o_RA1E      = ra1_q;
    assign o_RA2E      = ra2_q;
    assign o_WA3E      = wa3_q;
    assign o_RegWriteE = reg_write_q;
    assign o_MemToRegE = mem_to_reg_q;
    assign o_ValidE    = valid_q;
    assign o_StallReq  = stall_req;
endmodule

// File: tb/tb_arm_id_ex_operand_stage.sv
// tb_arm_id_ex_operand_stage: directed vectors for the D->E register, forwarding selects and load-use bubble.
module tb_arm_id_ex_operand_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, valid_d = 1'b0;
    logic [31:0] rd1_d = '0, rd2_d = '0, imm_d = '0;
    logic [3:0]  ra1_d = '0, ra2_d = '0, wa3_d = '0, wa3_m = '0, wa3_w = '0;
    logic        rw_d = 1'b0, m2r_d = 1'b0, rw_m = 1'b0, rw_w = 1'b0;
    logic [31:0] rd1_e, rd2_e, imm_e;
    logic [3:0]  ra1_e, ra2_e, wa3_e;
    logic        rw_e, m2r_e, valid_e, stall_req;
    logic [1:0]  fwd_a, fwd_b;
    int          n_chk = 0, n_err = 0;

    arm_id_ex_operand_stage dut (
        .i_CLK(clk), .i_NRESET(rst_n), .i_Stall(stall), .i_Flush(flush), .i_ValidD(valid_d),
        .i_RD1D(rd1_d), .i_RD2D(rd2_d), .i_ImmD(imm_d), .i_RA1D(ra1_d), .i_RA2D(ra2_d),
        .i_WA3D(wa3_d), .i_RegWriteD(rw_d), .i_MemToRegD(m2r_d), .i_WA3M(wa3_m), .i_WA3W(wa3_w),
        .i_RegWriteM(rw_m), .i_RegWriteW(rw_w), .o_RD1E(rd1_e), .o_RD2E(rd2_e), .o_ImmE(imm_e),
        .o_RA1E(ra1_e), .o_RA2E(ra2_e), .o_WA3E(wa3_e), .o_RegWriteE(rw_e), .o_MemToRegE(m2r_e),
        .o_ValidE(valid_e), .o_ForwardAE(fwd_a), .o_ForwardBE(fwd_b), .o_StallReq(stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r1, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] w, input logic rw, input logic m2r);
        valid_d = v; rd1_d = r1; rd2_d = ~r1; imm_d = r1 ^ 32'h00FF_00FF;
        ra1_d = a1; ra2_d = a2; wa3_d = w; rw_d = rw; m2r_d = m2r;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, 32'(valid_e), 32'd0);
        check({tag, "_rw"}, 32'(rw_e), 32'd0);
        check({tag, "_m2r"}, 32'(m2r_e), 32'd0);
        check({tag, "_rd1"}, rd1_e, 32'd0);
        check({tag, "_wa3"}, 32'(wa3_e), 32'd0);
    endtask

    initial begin
        // 1: reset state, then async reset mid-run
        #1;
        check_empty("rst0");
        check("rst0_fa", 32'(fwd_a), 32'd0);
        check("rst0_sr", 32'(stall_req), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 32'hCAFE_0001, 4'd1, 4'd2, 4'd6, 1'b1, 1'b0);
        step();
        check("run_valid", 32'(valid_e), 32'd1);
        check("run_rd1", rd1_e, 32'hCAFE_0001);
        #2 rst_n = 1'b0;
        #1;
        check_empty("rst1");
        // 2: first edge after release captures D
        drive(1'b1, 32'h1234_5678, 4'd3, 4'd4, 4'd7, 1'b1, 1'b0);
        rst_n = 1'b1;
        step();
        check("cap_rd1", rd1_e, 32'h1234_5678);
        check("cap_rd2", rd2_e, 32'hEDCB_A987);
        check("cap_imm", imm_e, 32'h12CB_5687);
        check("cap_wa3", 32'(wa3_e), 32'd7);
        check("cap_ra1", 32'(ra1_e), 32'd3);
        check("cap_valid", 32'(valid_e), 32'd1);
        check("cap_rw", 32'(rw_e), 32'd1);
        // invalid D never writes
        drive(1'b0, 32'h1, 4'd3, 4'd4, 4'd7, 1'b1, 1'b1);
        step();
        check("inv_valid", 32'(valid_e), 32'd0);
        check("inv_rw", 32'(rw_e), 32'd0);
        check("inv_m2r", 32'(m2r_e), 32'd0);
        // 3: forwarding
        drive(1'b1, 32'h5, 4'd5, 4'd9, 4'd8, 1'b1, 1'b0);
        step();
        wa3_m = 4'd5; rw_m = 1'b1; wa3_w = 4'd5; rw_w = 1'b1;
        #1;
        check("fwd_a_m", 32'(fwd_a), 32'd2);
        check("fwd_b_none", 32'(fwd_b), 32'd0);
        rw_m = 1'b0;
        #1;
        check("fwd_a_w", 32'(fwd_a), 32'd1);
        rw_w = 1'b0;
        #1;
        check("fwd_a_none", 32'(fwd_a), 32'd0);
        wa3_m = 4'd9; rw_m = 1'b1; rw_w = 1'b1;
        #1;
        check("fwd_b_m", 32'(fwd_b), 32'd2);
        check("fwd_a_w2", 32'(fwd_a), 32'd1);
        wa3_w = 4'd9; rw_m = 1'b0;
        #1;
        check("fwd_b_w", 32'(fwd_b), 32'd1);
        drive(1'b1, 32'h6, 4'd15, 4'd15, 4'd8, 1'b1, 1'b0);
        step();
        wa3_m = 4'd15; rw_m = 1'b1; wa3_w = 4'd15; rw_w = 1'b1;
        #1;
        check("fwd_a_pc", 32'(fwd_a), 32'd0);
        check("fwd_b_pc", 32'(fwd_b), 32'd0);
        rw_m = 1'b0; rw_w = 1'b0;
        // 4: load-use bubble
        drive(1'b1, 32'h7, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1);
        step();
        check("ld_m2r", 32'(m2r_e), 32'd1);
        check("ld_sr_idle", 32'(stall_req), 32'd0);
        drive(1'b1, 32'h8, 4'd4, 4'd2, 4'd3, 1'b1, 1'b0);
        #1;
        check("lu_sr", 32'(stall_req), 32'd1);
        valid_d = 1'b0;
        #1;
        check("lu_sr_inv", 32'(stall_req), 32'd0);
        valid_d = 1'b1;
        step();
        check_empty("bub");
        check("bub_sr", 32'(stall_req), 32'd0);
        step();
        check("post_ra2", 32'(ra2_e), 32'd2);
        check("post_valid", 32'(valid_e), 32'd1);
        // load into R15 never stalls
        drive(1'b1, 32'h9, 4'd0, 4'd0, 4'd15, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'hA, 4'd15, 4'd0, 4'd3, 1'b1, 1'b0);
        #1;
        check("lu_pc_sr", 32'(stall_req), 32'd0);
        // stall with pending load-use: hold, request persists
        drive(1'b1, 32'hB, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'hC, 4'd2, 4'd0, 4'd3, 1'b1, 1'b0);
        stall = 1'b1;
        step();
        check("lus_valid", 32'(valid_e), 32'd1);
        check("lus_wa3", 32'(wa3_e), 32'd2);
        check("lus_rd1", rd1_e, 32'hB);
        check("lus_sr", 32'(stall_req), 32'd1);
        stall = 1'b0;
        step();
        check("lus_bub", 32'(valid_e), 32'd0);
        // 5: flush beats stall
        drive(1'b1, 32'hD, 4'd1, 4'd1, 4'd4, 1'b1, 1'b0);
        step();
        flush = 1'b1; stall = 1'b1;
        step();
        check_empty("flush");
        flush = 1'b0; stall = 1'b0;
        // flush beats a pending load-use too
        drive(1'b1, 32'hE, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'hF, 4'd5, 4'd0, 4'd6, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        check_empty("flush_lu");
        flush = 1'b0;
        // 6: stall holds for two edges, release captures new D
        drive(1'b1, 32'hAAAA_0001, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
        step();
        stall = 1'b1;
        drive(1'b1, 32'hBBBB_0002, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'hCCCC_0003, 4'd7, 4'd8, 4'd9, 1'b0, 1'b0);
        step();
        check("stl_rd1", rd1_e, 32'hAAAA_0001);
        check("stl_wa3", 32'(wa3_e), 32'd3);
        check("stl_rw", 32'(rw_e), 32'd1);
        check("stl_valid", 32'(valid_e), 32'd1);
        stall = 1'b0;
        drive(1'b1, 32'hDDDD_0004, 4'd10, 4'd11, 4'd12, 1'b1, 1'b0);
        step();
        check("rel_rd1", rd1_e, 32'hDDDD_0004);
        check("rel_wa3", 32'(wa3_e), 32'd12);
        check("rel_ra2", 32'(ra2_e), 32'd11);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
